buf_rd_resp: RTL and testbench
==============================

// Module: buf_rd_resp
// PURPOSE
// Responder end of the buffer read interface (bce_k/braddr_k -> brdata_k/brvalid_k) driven by the act/weight loaders.
// Sits between those loaders and NB single-port SRAM banks; also accepts DMA fill writes into the same banks.
// Reads are never stalled (the requester has no ready) and return after a fixed latency.
// Fill writes yield to reads on bank conflict.
// PARAMETERS
// NB        4   number of banks / read ports (one requester port per bank)
// AW        15  row address width per bank
// DW        64  data width per bank word
// SRAM_LAT  1   SRAM macro read latency, cycles from registered ce to valid q
// PORTS
// clk          in   1          clock
// rst          in   1          synchronous reset, active-high
// bce          in   NB         read request per port, one word per asserted cycle
// braddr       in   NB*AW      read row address per port, slice k = port k
// brdata       out  NB*DW      read data per port
// brvalid      out  NB         read data valid per port
// fill_valid   in   1          DMA write request
// fill_ready   out  1          DMA write accepted this cycle
// fill_addr    in   AW+2       [AW+1:AW] bank select, [AW-1:0] row
// fill_data    in   DW         write data
// sram_ce      out  NB         bank chip enable
// sram_we      out  NB         bank write enable (valid only with sram_ce)
// sram_addr    out  NB*AW      bank row address
// sram_wdata   out  NB*DW      bank write data
// sram_rdata   in   NB*DW      bank read data, valid SRAM_LAT cycles after ce&!we
// stall_clr    in   1          clear stall counter
// stall_cnt    out  32         cycles with fill_valid & !fill_ready
// BEHAVIOUR
// - Reset: sram_ce/we=0, sram_addr/wdata=0, brvalid=0, brdata=0, stall_cnt=0, read pipeline flushed.
// - Reset mid-operation: in-flight reads dropped; brvalid 0 from the first cycle after rst sampled high; no brvalid for any pre-reset request.
// - Request stage (registered): bce[k] at edge T -> sram_ce[k]=1, we=0, addr=braddr_k at T+1.
// - Read latency RD_LAT = 1 + SRAM_LAT + 1 (default 3): brvalid[k]=1 exactly RD_LAT cycles after bce[k], one pulse per request.
//   - brdata_k is registered from sram_rdata and held until the next valid.
//   - Back-to-back requests give back-to-back valids in order.
// - Per-port valid shift register, depth RD_LAT-1, tracks in-flight reads; no tags, no reordering.
// - Fill arbitration: b = fill_addr[AW+1:AW].
//   - fill_ready = fill_valid & !bce[b] (combinational).
//   - A read always wins the bank.
// - Accepted fill at T -> sram_ce[b]=1, sram_we[b]=1, addr=row, wdata=fill_data at T+1; no brvalid generated.
// - Fill and reads to different banks in the same cycle: both proceed.
// - Read at T+1 of the row written by a fill accepted at T returns the new data (SRAM write-then-read ordering).
// - stall_cnt: +1 per cycle with fill_valid & !fill_ready; saturates at 2^32-1.
//   - stall_clr has priority over increment (clears to 0 that cycle).
// - All NB ports are independent; all ports requesting simultaneously are served in parallel.
// STRUCTURE
// - Package buf_pkg: AW, DW, NB defaults; bank/row split function for fill_addr; RD_LAT derived constant.
// - Sub-module buf_bank_port, generated once per bank: request register, write mux, valid shift register, output data register.
// - Top level: fill bank decode, fill_ready, stall counter, generate loop.
// TESTING
// 1. Single read port0 addr 0x0010, SRAM model preloaded 0xA5A5... -> brvalid[0] exactly 3 cycles later, brdata_0=0xA5A5...; no other valid.
// 2. 16 back-to-back reads, all 4 ports, addr 0..15 -> 16 contiguous valids per port, in address order, data matching the model.
// 3. Conflict: fill_valid to bank 2 with bce[2]=1 for 5 cycles -> fill_ready=0 for 5 cycles, stall_cnt=5; write lands the cycle after bce[2] drops.
// 4. Non-conflict: fill to bank 1 while reading banks 0/2/3 -> fill_ready=1 the same cycle, sram_we[1]=1 next cycle, reads unaffected.
// 5. Fill 0xDEAD_BEEF to bank0 row 7, then read row 7 the next cycle -> brdata_0=0xDEAD_BEEF.
// 6. rst pulse with 2 reads in flight -> no brvalid after reset, all outputs 0.
//    After stall_clr with fill_valid asserted in the same cycle -> stall_cnt=0 that cycle.

Source files
------------

// File: rtl/buf_pkg.sv
// ---------------------------------------------------------------------------
// buf_pkg
// Shared constants and helpers for the buffer read responder.
//   BUF_NB / BUF_AW / BUF_DW / BUF_SRAM_LAT : default bank count, row address
//                                             width, word width, SRAM latency
//   BANK_SEL_W : width of the bank-select field on top of the fill row address
//   RD_LAT     : request-to-valid latency for the default SRAM latency
//   fill_bank(): extracts the bank select from a fill address
//   rd_lat()   : request-to-valid latency for an arbitrary SRAM latency
// ---------------------------------------------------------------------------
package buf_pkg;

  localparam int BUF_NB       = 4;
  localparam int BUF_AW       = 15;
  localparam int BUF_DW       = 64;
  localparam int BUF_SRAM_LAT = 1;

  // The fill address carries a 2-bit bank select above the row bits.
  localparam int BANK_SEL_W = 2;

  // Request register + SRAM macro + output data register.
  localparam int RD_LAT = 1 + BUF_SRAM_LAT + 1;

  function automatic int unsigned rd_lat(input int unsigned sram_lat);
    return sram_lat + 2;
  endfunction

  // Bank select sits directly above the aw row bits of a fill address.
  function automatic logic [BANK_SEL_W-1:0] fill_bank(input logic [31:0] addr,
                                                      input int unsigned aw);
    logic [31:0] shifted;
    shifted = addr >> aw;
    return shifted[BANK_SEL_W-1:0];
  endfunction

endpackage

// File: rtl/buf_bank_port.sv
// ---------------------------------------------------------------------------
// buf_bank_port
// One bank of the buffer: registers the read request or an accepted fill
// write towards the SRAM macro, tracks in-flight reads in a valid shift
// register and registers the returned word for the requester.
//   clk, rst        : clock, synchronous active-high reset
//   rd_req_i/addr_i : read request and row from the loader port
//   wr_req_i/addr_i : fill write already granted for this bank, row, data
//   wr_data_i
//   sram_*_o        : registered SRAM macro controls
//   sram_rdata_i    : SRAM macro read data, valid SRAM_LAT cycles after ce
//   rd_data_o       : read data, held until the next valid
//   rd_valid_o      : one pulse per read, RD_LAT cycles after rd_req_i
// ---------------------------------------------------------------------------
module buf_bank_port #(
  parameter int AW       = 15,
  parameter int DW       = 64,
  parameter int SRAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          sram_ce_o,
  output logic          sram_we_o,
  output logic [AW-1:0] sram_addr_o,
  output logic [DW-1:0] sram_wdata_o,
  input  logic [DW-1:0] sram_rdata_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_valid_o
);

  // Stage 0 lines up with the registered ce, the last stage with the cycle
  // the macro presents q; the output register adds the final cycle.
  localparam int VLD_DEPTH = SRAM_LAT + 1;

  logic                 ce_q,     ce_d;
  logic                 we_q,     we_d;
  logic [AW-1:0]        addr_q,   addr_d;
  logic [DW-1:0]        wdata_q,  wdata_d;
  logic [VLD_DEPTH-1:0] vld_q,    vld_d;
  logic                 rvalid_q, rvalid_d;
  logic [DW-1:0]        rdata_q,  rdata_d;

  always_comb begin
    // NOTE: every _d takes its hold value first so no path can infer a latch.
    ce_d     = 1'b0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    vld_d    = (vld_q << 1) | VLD_DEPTH'(rd_req_i);
    rvalid_d = vld_q[VLD_DEPTH-1];
    rdata_d  = rdata_q;

    // A read always owns the bank; a fill only gets here when granted.
    if (rd_req_i) begin
      ce_d   = 1'b1;
      addr_d = rd_addr_i;
    end else if (wr_req_i) begin
      ce_d    = 1'b1;
      we_d    = 1'b1;
      addr_d  = wr_addr_i;
      wdata_d = wr_data_i;
    end

    if (vld_q[VLD_DEPTH-1]) begin
      rdata_d = sram_rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update
    // from the same pre-edge values.
    if (rst) begin
      ce_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      vld_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ce_q     <= ce_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      vld_q    <= vld_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign sram_ce_o    = ce_q;
  assign sram_we_o    = we_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;
  assign rd_data_o    = rdata_q;
  assign rd_valid_o   = rvalid_q;

endmodule

// File: rtl/buf_rd_resp.sv
// ---------------------------------------------------------------------------
// buf_rd_resp
// Responder end of the loader buffer read interface. Each of NB ports owns
// one single-port SRAM bank; reads are never stalled and return after a fixed
// latency. DMA fill writes share the banks and yield on conflict.
//   clk, rst                : clock, synchronous active-high reset
//   bce, braddr             : per-port read request and row address
//   brdata, brvalid         : per-port read data and valid pulse
//   fill_valid/ready        : DMA write handshake (ready is combinational)
//   fill_addr, fill_data    : {bank, row} and write word
//   sram_ce/we/addr/wdata   : per-bank SRAM macro controls
//   sram_rdata              : per-bank SRAM macro read data
//   stall_clr, stall_cnt    : saturating count of refused fill cycles
// ---------------------------------------------------------------------------
module buf_rd_resp
  import buf_pkg::*;
#(
  parameter int NB       = BUF_NB,
  parameter int AW       = BUF_AW,
  parameter int DW       = BUF_DW,
  parameter int SRAM_LAT = BUF_SRAM_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NB-1:0]    bce,
  input  logic [NB*AW-1:0] braddr,
  output logic [NB*DW-1:0] brdata,
  output logic [NB-1:0]    brvalid,
  input  logic             fill_valid,
  output logic             fill_ready,
  input  logic [AW+1:0]    fill_addr,
  input  logic [DW-1:0]    fill_data,
  output logic [NB-1:0]    sram_ce,
  output logic [NB-1:0]    sram_we,
  output logic [NB*AW-1:0] sram_addr,
  output logic [NB*DW-1:0] sram_wdata,
  input  logic [NB*DW-1:0] sram_rdata,
  input  logic             stall_clr,
  output logic [31:0]      stall_cnt
);

  logic [BANK_SEL_W-1:0] fill_bank_w;
  logic [AW-1:0]         fill_row_w;
  logic [NB-1:0]         fill_sel;
  logic [31:0]           stall_q, stall_d;

  assign fill_bank_w = fill_bank(32'(fill_addr), AW);
  assign fill_row_w  = fill_addr[AW-1:0];

  // A read request on the target bank always beats the fill.
  assign fill_ready = fill_valid & ~bce[fill_bank_w];

  always_comb begin
    fill_sel = '0;
    if (fill_ready) begin
      fill_sel[fill_bank_w] = 1'b1;
    end
  end

  // Clear wins over increment; the count sticks at all-ones.
  always_comb begin
    stall_d = stall_q;
    if (stall_clr) begin
      stall_d = '0;
    end else if (fill_valid && !fill_ready && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;

  for (genvar k = 0; k < NB; k++) begin : g_port
    buf_bank_port #(
      .AW       (AW),
      .DW       (DW),
      .SRAM_LAT (SRAM_LAT)
    ) u_port (
      .clk          (clk),
      .rst          (rst),
      .rd_req_i     (bce[k]),
      .rd_addr_i    (braddr[k*AW +: AW]),
      .wr_req_i     (fill_sel[k]),
      .wr_addr_i    (fill_row_w),
      .wr_data_i    (fill_data),
      .sram_ce_o    (sram_ce[k]),
      .sram_we_o    (sram_we[k]),
      .sram_addr_o  (sram_addr[k*AW +: AW]),
      .sram_wdata_o (sram_wdata[k*DW +: DW]),
      .sram_rdata_i (sram_rdata[k*DW +: DW]),
      .rd_data_o    (brdata[k*DW +: DW]),
      .rd_valid_o   (brvalid[k])
    );
  end

endmodule

// File: tb/tb_buf_rd_resp.sv
// ---------------------------------------------------------------------------
// tb_buf_rd_resp
// Directed bench for buf_rd_resp. Reads push their expected word and due
// cycle into a per-port queue; a negedge monitor pops and compares whenever
// brvalid is seen, and flags valids that are unexpected or overdue. A simple
// 1-cycle SRAM model sits on the bank side.
// ---------------------------------------------------------------------------
module tb_buf_rd_resp;

  localparam int NB = 4;
  localparam int AW = 15;
  localparam int DW = 64;
  localparam int LAT = 3;

  logic             clk;
  logic             rst;
  logic [NB-1:0]    bce;
  logic [NB*AW-1:0] braddr;
  logic [NB*DW-1:0] brdata;
  logic [NB-1:0]    brvalid;
  logic             fill_valid;
  logic             fill_ready;
  logic [AW+1:0]    fill_addr;
  logic [DW-1:0]    fill_data;
  logic [NB-1:0]    sram_ce;
  logic [NB-1:0]    sram_we;
  logic [NB*AW-1:0] sram_addr;
  logic [NB*DW-1:0] sram_wdata;
  logic [NB*DW-1:0] sram_rdata;
  logic             stall_clr;
  logic [31:0]      stall_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t sb [NB][$];

  localparam logic [DW-1:0] W_CONF = 64'h1122_3344_5566_7788;
  localparam logic [DW-1:0] W_NC   = 64'h0F0F_1234_ABCD_5678;
  localparam logic [DW-1:0] W_BEEF = 64'h0000_0000_DEAD_BEEF;

  buf_rd_resp u_dut (
    .clk        (clk),
    .rst        (rst),
    .bce        (bce),
    .braddr     (braddr),
    .brdata     (brdata),
    .brvalid    (brvalid),
    .fill_valid (fill_valid),
    .fill_ready (fill_ready),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .stall_clr  (stall_clr),
    .stall_cnt  (stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Preload contents of every bank; bank 0 row 0x10 holds the A5 pattern.
  function automatic logic [DW-1:0] pat(input int b, input int a);
    if (b == 0 && a == 16) return 64'hA5A5_A5A5_A5A5_A5A5;
    return {8'hC0 + 8'(b), 24'(a), (32'(a) * 32'h9E37_79B1) ^ 32'(b)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM model: 1-cycle read latency, unwritten rows return the preload.
  logic [DW-1:0] wmem [int];
  always @(posedge clk) begin
    int key;
    int row;
    for (int k = 0; k < NB; k++) begin
      if (sram_ce[k]) begin
        row = int'(sram_addr[k*AW +: AW]);
        key = k * 65536 + row;
        if (sram_we[k]) begin
          wmem[key] = sram_wdata[k*DW +: DW];
        end else begin
          sram_rdata[k*DW +: DW] <= wmem.exists(key) ? wmem[key] : pat(k, row);
        end
      end
    end
  end

  // Monitor: compares every valid against the head of its port queue.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < NB; k++) begin
      if (brvalid[k]) begin
        if (sb[k].size() == 0) begin
          check($sformatf("unexpected_valid_p%0d", k), 64'd1, 64'd0);
        end else begin
          e = sb[k].pop_front();
          check($sformatf("rd_data_p%0d", k), brdata[k*DW +: DW], e.data);
          check($sformatf("rd_latency_p%0d", k), 64'(cyc), 64'(e.due));
        end
      end else if (sb[k].size() > 0 && sb[k][0].due <= cyc) begin
        check($sformatf("missing_valid_p%0d", k), 64'd0, 64'd1);
        e = sb[k].pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bce        = '0;
    fill_valid = 1'b0;
    stall_clr  = 1'b0;
  endtask

  task automatic rd(input int k, input int a, input logic [DW-1:0] d);
    exp_t e;
    bce[k]               = 1'b1;
    braddr[k*AW +: AW]   = AW'(a);
    e.data               = d;
    e.due                = cyc + LAT;
    sb[k].push_back(e);
  endtask

  task automatic fill(input int b, input int row, input logic [DW-1:0] d);
    fill_valid = 1'b1;
    fill_addr  = {2'(b), AW'(row)};
    fill_data  = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;
    rst       = 1'b1;
    braddr    = '0;
    fill_addr = '0;
    fill_data = '0;
    idle();
    repeat (2) tick();

    // Reset state
    check("rst_brvalid", 64'(brvalid), 64'd0);
    check("rst_sram_ce", 64'(sram_ce), 64'd0);
    check("rst_sram_we", 64'(sram_we), 64'd0);
    check("rst_sram_addr_zero", 64'(sram_addr != '0), 64'd0);
    check("rst_sram_wdata_zero", 64'(sram_wdata != '0), 64'd0);
    check("rst_brdata_zero", 64'(brdata != '0), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // 1. Single read, port 0, row 0x10
    rd(0, 16, 64'hA5A5_A5A5_A5A5_A5A5);
    tick();
    check("t1_sram_ce0", 64'(sram_ce), 64'h1);
    check("t1_sram_addr0", 64'(sram_addr[0 +: AW]), 64'h10);
    idle();
    repeat (5) tick();

    // 2. 16 back-to-back reads on all ports
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < NB; k++) rd(k, i, pat(k, i));
      tick();
    end
    idle();
    repeat (5) tick();

    // 3. Conflict on bank 2 for 5 cycles
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd(2, 32 + i, pat(2, 32 + i));
      fill(2, 48, W_CONF);
      #1;
      check("t3_conflict_ready", 64'(fill_ready), 64'd0);
      tick();
      check("t3_no_write_during_read", 64'(sram_we[2]), 64'd0);
    end
    bce = '0;
    #1;
    check("t3_ready_after_drop", 64'(fill_ready), 64'd1);
    check("t3_stall_cnt", 64'(stall_cnt), 64'd5);
    tick();
    fill_valid = 1'b0;
    check("t3_write_ce", 64'(sram_ce[2]), 64'd1);
    check("t3_write_we", 64'(sram_we[2]), 64'd1);
    check("t3_write_addr", 64'(sram_addr[2*AW +: AW]), 64'd48);
    check("t3_write_data", sram_wdata[2*DW +: DW], W_CONF);
    check("t3_stall_hold", 64'(stall_cnt), 64'd5);
    repeat (3) tick();
    rd(2, 48, W_CONF);
    tick();
    idle();
    repeat (5) tick();

    // 4. Fill bank 1 while reading banks 0/2/3
    rd(0, 5, pat(0, 5));
    rd(2, 5, pat(2, 5));
    rd(3, 5, pat(3, 5));
    fill(1, 3, W_NC);
    #1;
    check("t4_ready_same_cycle", 64'(fill_ready), 64'd1);
    tick();
    idle();
    check("t4_ce", 64'(sram_ce), 64'hF);
    check("t4_we", 64'(sram_we), 64'h2);
    repeat (3) tick();
    rd(1, 3, W_NC);
    tick();
    idle();
    repeat (5) tick();

    // 5. Fill then read the same row the next cycle
    fill(0, 7, W_BEEF);
    tick();
    fill_valid = 1'b0;
    rd(0, 7, W_BEEF);
    tick();
    idle();
    repeat (5) tick();

    // stall_clr has priority over a stalled fill
    rd(3, 9, pat(3, 9));
    fill(3, 1, W_NC);
    tick();
    check("stall_inc", 64'(stall_cnt), 64'd6);
    rd(3, 10, pat(3, 10));
    stall_clr = 1'b1;
    #1;
    check("clr_cycle_ready", 64'(fill_ready), 64'd0);
    tick();
    check("stall_clr_priority", 64'(stall_cnt), 64'd0);
    stall_clr = 1'b0;
    rd(3, 11, pat(3, 11));
    tick();
    check("stall_after_clr", 64'(stall_cnt), 64'd1);
    idle();
    repeat (5) tick();

    // 6. Reset with two reads in flight: nothing may come back
    bce[0]             = 1'b1;
    braddr[0 +: AW]    = AW'(1);
    bce[1]             = 1'b1;
    braddr[AW +: AW]   = AW'(2);
    tick();
    idle();
    rst = 1'b1;
    tick();
    check("t6_brvalid", 64'(brvalid), 64'd0);
    check("t6_brdata_zero", 64'(brdata != '0), 64'd0);
    check("t6_sram_ce", 64'(sram_ce), 64'd0);
    check("t6_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();
    rst = 1'b0;
    repeat (6) tick();
    check("t6_no_late_valid", 64'(brvalid), 64'd0);

    // Every pushed expectation must have been consumed
    waited = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && waited < 20) begin
      tick();
      waited++;
    end
    check("scoreboard_drained",
          64'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
